// File: rtl/alu_multdiv_seq_if.sv
// Bundle between the execute pipeline, the multiply/divide sequencer and the shared ALU.
// The sequencer is the slave. The pipeline, which also hosts the shared ALU, is the master.
interface alu_multdiv_seq_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        data_busy;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [31:0] alu_result;

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result,
    output data_result, data_exception, data_resultRDY, data_busy,
    output alu_opcode, alu_operandA, alu_operandB
  );

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result,
    input  data_result, data_exception, data_resultRDY, data_busy,
    input  alu_opcode, alu_operandA, alu_operandB
  );
endinterface

// File: rtl/alu_multdiv_seq.sv
// Signed 32-bit multiply (shift-add) / divide (restoring) sequencer that borrows the shared ALU.
// The sequence is sign-strip, 32 iterations, then sign-fix. A done pulse arrives 35 edges after the start edge.
module alu_multdiv_seq #(
  parameter int         WIDTH  = 32,
  parameter int         ITER   = 32,
  parameter logic [4:0] OP_ADD = 5'b00000,
  parameter logic [4:0] OP_SUB = 5'b00001
) (
  input  logic               clock,
  input  logic               reset_n,
  alu_multdiv_seq_if.slave   bus
);
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NEGA = 3'd1,
    S_NEGB = 3'd2,
    S_ITER = 3'd3,
    S_FIX  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;

  logic [4:0]         alu_op;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   add_b;
  logic               carry;
  logic [WIDTH-1:0]   trial;
  logic               borrow;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_q   <= sign_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_d   = sign_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    result_d = result_q;
    exc_d    = exc_q;
    alu_op   = OP_ADD;
    alu_a    = '0;
    alu_b    = '0;
    b_abs    = '0;
    sum      = '0;
    add_b    = '0;
    carry    = 1'b0;
    trial    = '0;
    borrow   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
          is_div_d = !bus.ctrl_MULT;
          a_d      = bus.data_operandA;
          b_d      = bus.data_operandB;
          sign_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
          cnt_d    = '0;
          if (!bus.ctrl_MULT && bus.data_operandB == '0) begin
            result_d = '0;
            exc_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_NEGA;
          end
        end
      end

      S_NEGA: begin
        alu_op  = OP_SUB;
        alu_b   = a_q;
        a_d     = a_q[WIDTH-1] ? bus.alu_result : a_q;
        state_d = S_NEGB;
      end

      S_NEGB: begin
        alu_op  = OP_SUB;
        alu_b   = b_q;
        b_abs   = b_q[WIDTH-1] ? bus.alu_result : b_q;
        b_d     = b_abs;
        // Low half holds the multiplier for MULT, the dividend for DIV. The high half starts at zero.
        p_d     = is_div_q ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{1'b0}}, b_abs};
        state_d = S_ITER;
      end

      S_ITER: begin
        if (!is_div_q) begin
          alu_op = OP_ADD;
          alu_a  = p_q[2*WIDTH-1:WIDTH];
          alu_b  = a_q;
          add_b  = p_q[0] ? a_q : '0;
          sum    = p_q[0] ? bus.alu_result : p_q[2*WIDTH-1:WIDTH];
          carry  = (alu_a[WIDTH-1] & add_b[WIDTH-1]) |
                   ((alu_a[WIDTH-1] | add_b[WIDTH-1]) & ~sum[WIDTH-1]);
          p_d    = {carry, sum, p_q[WIDTH-1:1]};
        end else begin
          trial  = {p_q[2*WIDTH-2:WIDTH], p_q[WIDTH-1]};
          alu_op = OP_SUB;
          alu_a  = trial;
          alu_b  = b_q;
          // A set remainder MSB means the true trial value is >= 2^32 and always covers the divisor.
          borrow = !p_q[2*WIDTH-1] && (trial < b_q);
          p_d    = {(borrow ? trial : bus.alu_result), p_q[WIDTH-2:0], ~borrow};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end

      S_FIX: begin
        alu_op   = OP_SUB;
        alu_b    = p_q[WIDTH-1:0];
        result_d = sign_q ? bus.alu_result : p_q[WIDTH-1:0];
        if (is_div_q)
          exc_d = (p_q[WIDTH-1:0] == {1'b1, {(WIDTH-1){1'b0}}}) && !sign_q;
        else
          exc_d = (p_q[2*WIDTH-1:WIDTH] != '0) ||
                  (p_q[WIDTH-1] && !(sign_q && p_q[WIDTH-2:0] == '0));
        state_d = S_DONE;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.alu_opcode     = alu_op;
  assign bus.alu_operandA   = alu_a;
  assign bus.alu_operandB   = alu_b;
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == S_DONE);
  assign bus.data_busy      = (state_q == S_NEGA) || (state_q == S_NEGB) ||
                              (state_q == S_ITER) || (state_q == S_FIX);
endmodule

// File: tb/tb_alu_multdiv_seq.sv
// Bench for alu_multdiv_seq: it models the shared ALU and checks each operation against signed integer arithmetic.
module tb_alu_multdiv_seq;
  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_multdiv_seq_if bus ();

  alu_multdiv_seq dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The shared ALU only needs ADD and SUB here.
  always_comb begin
    if (bus.alu_opcode == 5'b00001) bus.alu_result = bus.alu_operandA - bus.alu_operandB;
    else                            bus.alu_result = bus.alu_operandA + bus.alu_operandB;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output bit exc);
    longint sa, sb, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      res = sa * sb;
      exc = (res > 64'sd2147483647) || (res < -64'sd2147483648);
    end else if (sb == 0) begin
      res = 0;
      exc = 1'b1;
    end else begin
      res = sa / sb;
      exc = (res > 64'sd2147483647);
    end
    r = res[31:0];
  endfunction

  // Latency is counted in rising edges after the start edge.
  task automatic run_op(input string tag, input bit is_div, input logic [31:0] a,
                        input logic [31:0] b, input bit both, input bit poke);
    logic [31:0] er;
    bit          ee;
    bit          eff_div;
    int          n;
    int          exp_lat;
    bit          busy_bad;
    eff_div = is_div && !both;
    ref_model(eff_div, a, b, er, ee);
    exp_lat = (eff_div && b == 32'd0) ? 0 : 35;
    bus.ctrl_MULT     = !is_div || both;
    bus.ctrl_DIV      = is_div || both;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    n        = 0;
    busy_bad = 1'b0;
    while (!bus.data_resultRDY && n < 100) begin
      if (!bus.data_busy) busy_bad = 1'b1;
      if (poke && n == 10) begin
        bus.ctrl_MULT = 1'b1;
        bus.ctrl_DIV  = 1'b1;
      end else begin
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
      end
      @(posedge clock);
      #1;
      n++;
    end
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " busy while running"}, 64'(busy_bad), 64'd0);
    check({tag, " result"}, 64'(bus.data_result), 64'(er));
    check({tag, " exception"}, 64'(bus.data_exception), 64'(ee));
    check({tag, " busy at rdy"}, 64'(bus.data_busy), 64'd0);
    @(posedge clock);
    #1;
    check({tag, " rdy one cycle"}, 64'(bus.data_resultRDY), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 200)) - 32'd100;
      4:       v = 32'($urandom_range(0, 65535));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    bit          rdy_seen;
    logic [31:0] ra, rb;
    reset_n           = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset result", 64'(bus.data_result), 64'd0);
    check("reset exc", 64'(bus.data_exception), 64'd0);
    check("reset rdy", 64'(bus.data_resultRDY), 64'd0);
    check("reset busy", 64'(bus.data_busy), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run_op("mult 7*-6", 1'b0, 32'd7, 32'hFFFF_FFFA, 1'b0, 1'b0);
    run_op("mult 2^16*2^16", 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
    run_op("mult -2^31*1", 1'b0, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
    run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("div -2^31/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div 5/0", 1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op("both 3,4", 1'b1, 32'd3, 32'd4, 1'b1, 1'b0);
    run_op("poke mult", 1'b0, 32'd1234, 32'hFFFF_FF00, 1'b0, 1'b1);
    run_op("poke div", 1'b1, 32'd100000, 32'hFFFF_FFF3, 1'b0, 1'b1);

    check("idle alu opcode", 64'(bus.alu_opcode), 64'd0);
    check("idle alu opA", 64'(bus.alu_operandA), 64'd0);
    check("idle alu opB", 64'(bus.alu_operandB), 64'd0);

    // Abort partway through the iterations: start, then 12 more edges lands in iteration 10.
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd123456;
    bus.data_operandB = 32'hFFFF_FCEB;
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort result", 64'(bus.data_result), 64'd0);
    check("abort exc", 64'(bus.data_exception), 64'd0);
    check("abort rdy", 64'(bus.data_resultRDY), 64'd0);
    check("abort busy", 64'(bus.data_busy), 64'd0);
    check("abort alu", {27'd0, bus.alu_opcode, bus.alu_operandA | bus.alu_operandB}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n  = 1'b1;
    rdy_seen = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY || bus.data_busy) rdy_seen = 1'b1;
    end
    check("no rdy after abort", 64'(rdy_seen), 64'd0);
    run_op("mult after abort", 1'b0, 32'hFFFF_FF85, 32'd77, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = pick();
      run_op($sformatf("rand%0d", i), bit'($urandom_range(0, 1)), ra, rb, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
